pipeline_id_hazard_stage: RTL and testbench

Parametrised next-generation decode stage for the 5-stage MIPS pipeline.
- Holds the register file and forwards operands from MEM and WB.
- Detects load-use and branch-operand hazards and stalls for them.
- Resolves conditional branches in ID with a signed offset, and drives a registered ID/EX pipeline register that honours backpressure from EX.
- Sits between the IF/ID register and the EX stage. External control decode supplies nothing to it; it decodes opcode/funct fields itself for hazard and branch purposes only.

---
 rtl/pipeline_id_hazard_stage_pkg.sv | 36 +++
 rtl/pipeline_id_hazard_stage_if.sv | 52 +++++
 rtl/pipeline_id_hazard_stage_regfile_bypass.sv | 42 ++++
 rtl/pipeline_id_hazard_stage.sv | 153 +++++++++++++++
 tb/tb_pipeline_id_hazard_stage.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_id_hazard_stage_pkg.sv
// ---------------------------------------------------------------------------
// mips_pkg: opcode constants, default widths and helpers for the ID stage
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mips_pkg;

  localparam int DEF_DATA_W = 32;

  typedef logic [5:0] opcode_t;

  localparam opcode_t OP_RTYPE  = 6'h00;
  localparam opcode_t OP_REGIMM = 6'h01;
  localparam opcode_t OP_JAL    = 6'h03;
  localparam opcode_t OP_BEQ    = 6'h04;
  localparam opcode_t OP_BNE    = 6'h05;
  localparam opcode_t OP_BLEZ   = 6'h06;
  localparam opcode_t OP_BGTZ   = 6'h07;
  localparam opcode_t OP_SB     = 6'h28;
  localparam opcode_t OP_SH     = 6'h29;
  localparam opcode_t OP_SWL    = 6'h2A;
  localparam opcode_t OP_SW     = 6'h2B;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) res = i + 1;
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipeline_id_hazard_stage_if.sv
// ---------------------------------------------------------------------------
// pipeline_id_hazard_stage_if: IF/ID, EX/MEM/WB feedback and ID/EX bundle
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface pipeline_id_hazard_stage_if #(
  parameter int DATA_W = 32,
  parameter int AW     = 5
);
  logic              id_valid;
  logic [DATA_W-1:0] id_pc;
  logic [31:0]       id_instr;
  logic              ex_stall;
  logic              id_ready;
  logic              ex_regwr;
  logic              ex_memrd;
  logic [AW-1:0]     ex_wrreg;
  logic              mem_regwr;
  logic [AW-1:0]     mem_wrreg;
  logic [DATA_W-1:0] mem_data;
  logic              wb_regwr;
  logic [AW-1:0]     wb_wrreg;
  logic [DATA_W-1:0] wb_data;
  logic              ifid_flush;
  logic [DATA_W-1:0] branch_target;
  logic              idex_valid;
  logic [DATA_W-1:0] idex_pc;
  logic [DATA_W-1:0] idex_busa;
  logic [DATA_W-1:0] idex_busb;
  logic [DATA_W-1:0] idex_imm;
  logic [AW-1:0]     idex_wrreg;
  logic [5:0]        idex_opcode;
  logic [5:0]        idex_funct;

  modport master (
    output id_valid, id_pc, id_instr, ex_stall, ex_regwr, ex_memrd, ex_wrreg,
           mem_regwr, mem_wrreg, mem_data, wb_regwr, wb_wrreg, wb_data,
    input  id_ready, ifid_flush, branch_target, idex_valid, idex_pc, idex_busa,
           idex_busb, idex_imm, idex_wrreg, idex_opcode, idex_funct
  );

  modport slave (
    input  id_valid, id_pc, id_instr, ex_stall, ex_regwr, ex_memrd, ex_wrreg,
           mem_regwr, mem_wrreg, mem_data, wb_regwr, wb_wrreg, wb_data,
    output id_ready, ifid_flush, branch_target, idex_valid, idex_pc, idex_busa,
           idex_busb, idex_imm, idex_wrreg, idex_opcode, idex_funct
  );

endinterface

`default_nettype wire

// File: rtl/pipeline_id_hazard_stage_regfile_bypass.sv
// ---------------------------------------------------------------------------
// regfile_bypass: 2R1W register file, same-cycle write-through, r0 reads zero
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module regfile_bypass
  import mips_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NREGS  = 32,
  parameter int AW     = clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr_a,
  input  logic [AW-1:0]     raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] r_mem [NREGS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) r_mem[i] <= '0;
    end else if (we && waddr != '0) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata_a = (raddr_a == '0)                ? '0    :
                   (we && waddr == raddr_a)       ? wdata : r_mem[raddr_a];
  assign rdata_b = (raddr_b == '0)                ? '0    :
                   (we && waddr == raddr_b)       ? wdata : r_mem[raddr_b];

endmodule

`default_nettype wire

// File: rtl/pipeline_id_hazard_stage.sv
// ---------------------------------------------------------------------------
// pipeline_id_hazard_stage: MIPS ID stage with forwarding, hazard stall, branch resolve
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pipeline_id_hazard_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NREGS  = 32,
  parameter int FWD_EN = 1
) (
  input logic                     clk,
  input logic                     reset,
  pipeline_id_hazard_stage_if.slave bus
);

  localparam int AW = clog2(NREGS);

  logic [5:0]        w_opcode;
  logic [5:0]        w_funct;
  logic [4:0]        w_rt_field;
  logic [AW-1:0]     w_rs, w_rt, w_rd, w_dest;
  logic [DATA_W-1:0] w_simm, w_rf_a, w_rf_b, w_opa, w_opb;
  logic              w_uses_rt, w_is_branch, w_ex_hit, w_hazard, w_stall, w_ready;
  logic              w_taken, w_a_neg, w_a_zero;
  logic              w_unused;

  assign w_opcode   = bus.id_instr[31:26];
  assign w_funct    = bus.id_instr[5:0];
  assign w_rt_field = bus.id_instr[20:16];
  assign w_rs       = bus.id_instr[21 +: AW];
  assign w_rt       = bus.id_instr[16 +: AW];
  assign w_rd       = bus.id_instr[11 +: AW];
  assign w_simm     = {{(DATA_W-16){bus.id_instr[15]}}, bus.id_instr[15:0]};
  assign w_unused   = ^bus.id_instr[25:6];

  regfile_bypass #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS),
    .AW     (AW)
  ) u_regfile (
    .clk     (clk),
    .reset   (reset),
    .we      (bus.wb_regwr),
    .waddr   (bus.wb_wrreg),
    .wdata   (bus.wb_data),
    .raddr_a (w_rs),
    .raddr_b (w_rt),
    .rdata_a (w_rf_a),
    .rdata_b (w_rf_b)
  );

  assign w_uses_rt = (w_opcode == OP_RTYPE) || (w_opcode == OP_BEQ) || (w_opcode == OP_BNE) ||
                     (w_opcode >= OP_SB && w_opcode <= OP_SW);
  assign w_is_branch = (w_opcode == OP_REGIMM) || (w_opcode == OP_BEQ) || (w_opcode == OP_BNE) ||
                       (w_opcode == OP_BLEZ) || (w_opcode == OP_BGTZ);

  assign w_ex_hit = bus.ex_regwr && (bus.ex_wrreg != '0) &&
                    ((bus.ex_wrreg == w_rs) || (w_uses_rt && bus.ex_wrreg == w_rt));

  generate
    if (FWD_EN != 0) begin : g_fwd
      // MEM is always forwardable to branches; only an EX producer must wait
      assign w_hazard = (bus.ex_memrd && w_ex_hit) || (w_is_branch && w_ex_hit);
      assign w_opa = (w_rs == '0) ? '0 :
                     (bus.mem_regwr && bus.mem_wrreg == w_rs) ? bus.mem_data : w_rf_a;
      assign w_opb = (w_rt == '0) ? '0 :
                     (bus.mem_regwr && bus.mem_wrreg == w_rt) ? bus.mem_data : w_rf_b;
    end else begin : g_nofwd
      logic w_mem_hit;
      assign w_mem_hit = bus.mem_regwr && (bus.mem_wrreg != '0) &&
                         ((bus.mem_wrreg == w_rs) || (w_uses_rt && bus.mem_wrreg == w_rt));
      assign w_hazard  = w_ex_hit || w_mem_hit;
      assign w_opa     = w_rf_a;
      assign w_opb     = w_rf_b;
    end
  endgenerate

  assign w_stall      = bus.id_valid && w_hazard;
  assign w_ready      = !bus.ex_stall && !w_stall;
  assign bus.id_ready = w_ready;

  assign w_a_neg  = w_opa[DATA_W-1];
  assign w_a_zero = (w_opa == '0);

  always_comb begin
    w_taken = 1'b0;
    case (w_opcode)
      OP_REGIMM: begin
        if (w_rt_field == 5'd0)      w_taken = w_a_neg;
        else if (w_rt_field == 5'd1) w_taken = !w_a_neg;
      end
      OP_BEQ:  w_taken = (w_opa == w_opb);
      OP_BNE:  w_taken = (w_opa != w_opb);
      OP_BLEZ: w_taken = w_a_neg || w_a_zero;
      OP_BGTZ: w_taken = !w_a_neg && !w_a_zero;
      default: w_taken = 1'b0;
    endcase
  end

  assign bus.ifid_flush    = bus.id_valid && w_taken && w_ready;
  assign bus.branch_target = bus.id_pc + DATA_W'(4) + {w_simm[DATA_W-3:0], 2'b00};

  always_comb begin
    w_dest = w_rt;
    case (w_opcode)
      OP_RTYPE: w_dest = w_rd;
      OP_JAL:   w_dest = AW'(NREGS - 1);
      default:  w_dest = w_rt;
    endcase
  end

  logic              r_valid;
  logic [DATA_W-1:0] r_pc, r_busa, r_busb, r_imm;
  logic [AW-1:0]     r_wrreg;
  logic [5:0]        r_opcode, r_funct;

  always_ff @(posedge clk) begin
    if (reset || (!bus.ex_stall && (w_stall || !bus.id_valid))) begin
      r_valid  <= 1'b0;
      r_pc     <= '0;
      r_busa   <= '0;
      r_busb   <= '0;
      r_imm    <= '0;
      r_wrreg  <= '0;
      r_opcode <= '0;
      r_funct  <= '0;
    end else if (!bus.ex_stall) begin
      r_valid  <= 1'b1;
      r_pc     <= bus.id_pc;
      r_busa   <= w_opa;
      r_busb   <= w_opb;
      r_imm    <= w_simm;
      r_wrreg  <= w_dest;
      r_opcode <= w_opcode;
      r_funct  <= w_funct;
    end
  end

  assign bus.idex_valid  = r_valid;
  assign bus.idex_pc     = r_pc;
  assign bus.idex_busa   = r_busa;
  assign bus.idex_busb   = r_busb;
  assign bus.idex_imm    = r_imm;
  assign bus.idex_wrreg  = r_wrreg;
  assign bus.idex_opcode = r_opcode;
  assign bus.idex_funct  = r_funct;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_id_hazard_stage.sv
// ---------------------------------------------------------------------------
// tb_pipeline_id_hazard_stage: directed checks of forwarding, hazards, branches
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pipeline_id_hazard_stage;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pipeline_id_hazard_stage_if #(.DATA_W(32), .AW(5)) bus_a ();
  pipeline_id_hazard_stage_if #(.DATA_W(32), .AW(5)) bus_b ();
  pipeline_id_hazard_stage_if #(.DATA_W(32), .AW(4)) bus_c ();

  pipeline_id_hazard_stage #(.DATA_W(32), .NREGS(32), .FWD_EN(1)) dut_fwd (
    .clk(clk), .reset(reset), .bus(bus_a));
  pipeline_id_hazard_stage #(.DATA_W(32), .NREGS(32), .FWD_EN(0)) dut_nofwd (
    .clk(clk), .reset(reset), .bus(bus_b));
  pipeline_id_hazard_stage #(.DATA_W(32), .NREGS(16), .FWD_EN(1)) dut_r16 (
    .clk(clk), .reset(reset), .bus(bus_c));

  assign bus_b.id_valid  = bus_a.id_valid;   assign bus_c.id_valid  = bus_a.id_valid;
  assign bus_b.id_pc     = bus_a.id_pc;      assign bus_c.id_pc     = bus_a.id_pc;
  assign bus_b.id_instr  = bus_a.id_instr;   assign bus_c.id_instr  = bus_a.id_instr;
  assign bus_b.ex_stall  = bus_a.ex_stall;   assign bus_c.ex_stall  = bus_a.ex_stall;
  assign bus_b.ex_regwr  = bus_a.ex_regwr;   assign bus_c.ex_regwr  = bus_a.ex_regwr;
  assign bus_b.ex_memrd  = bus_a.ex_memrd;   assign bus_c.ex_memrd  = bus_a.ex_memrd;
  assign bus_b.ex_wrreg  = bus_a.ex_wrreg;   assign bus_c.ex_wrreg  = bus_a.ex_wrreg[3:0];
  assign bus_b.mem_regwr = bus_a.mem_regwr;  assign bus_c.mem_regwr = bus_a.mem_regwr;
  assign bus_b.mem_wrreg = bus_a.mem_wrreg;  assign bus_c.mem_wrreg = bus_a.mem_wrreg[3:0];
  assign bus_b.mem_data  = bus_a.mem_data;   assign bus_c.mem_data  = bus_a.mem_data;
  assign bus_b.wb_regwr  = bus_a.wb_regwr;   assign bus_c.wb_regwr  = bus_a.wb_regwr;
  assign bus_b.wb_wrreg  = bus_a.wb_wrreg;   assign bus_c.wb_wrreg  = bus_a.wb_wrreg[3:0];
  assign bus_b.wb_data   = bus_a.wb_data;    assign bus_c.wb_data   = bus_a.wb_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus_a.id_valid  = 1'b0; bus_a.id_pc     = '0; bus_a.id_instr = '0;
    bus_a.ex_stall  = 1'b0; bus_a.ex_regwr  = 1'b0; bus_a.ex_memrd = 1'b0;
    bus_a.ex_wrreg  = '0;   bus_a.mem_regwr = 1'b0; bus_a.mem_wrreg = '0;
    bus_a.mem_data  = '0;   bus_a.wb_regwr  = 1'b0; bus_a.wb_wrreg = '0;
    bus_a.wb_data   = '0;
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'h00, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    idle();
    tick();
    tick();
    reset = 1'b0;

    check("rst_valid",  32'(bus_a.idex_valid), 32'h0);
    check("rst_pc",     bus_a.idex_pc, 32'h0);
    check("rst_busa",   bus_a.idex_busa, 32'h0);
    check("rst_busb",   bus_a.idex_busb, 32'h0);
    check("rst_imm",    bus_a.idex_imm, 32'h0);
    check("rst_wrreg",  32'(bus_a.idex_wrreg), 32'h0);
    check("rst_opcode", 32'(bus_a.idex_opcode), 32'h0);
    check("rst_funct",  32'(bus_a.idex_funct), 32'h0);
    check("rst_flush",  32'(bus_a.ifid_flush), 32'h0);

    // WB writes r5, then addu r7,r5,r0 reads it from the register file
    bus_a.wb_regwr = 1'b1; bus_a.wb_wrreg = 5'd5; bus_a.wb_data = 32'h1234;
    tick();
    bus_a.wb_regwr = 1'b0;
    bus_a.id_valid = 1'b1; bus_a.id_pc = 32'h40; bus_a.id_instr = rtype(5'd5, 5'd0, 5'd7, 6'h21);
    #1;
    check("wb_ready", 32'(bus_a.id_ready), 32'h1);
    tick();
    check("wb_valid", 32'(bus_a.idex_valid), 32'h1);
    check("wb_busa",  bus_a.idex_busa, 32'h1234);
    check("wb_wrreg", 32'(bus_a.idex_wrreg), 32'd7);
    check("wb_funct", 32'(bus_a.idex_funct), 32'h21);
    check("wb_pc",    bus_a.idex_pc, 32'h40);

    // MEM and WB both target r3: MEM wins; the no-forward build stalls
    bus_a.id_instr  = rtype(5'd3, 5'd0, 5'd8, 6'h21);
    bus_a.mem_regwr = 1'b1; bus_a.mem_wrreg = 5'd3; bus_a.mem_data = 32'hAAAA;
    bus_a.wb_regwr  = 1'b1; bus_a.wb_wrreg  = 5'd3; bus_a.wb_data  = 32'h5555;
    #1;
    check("fwd_ready",   32'(bus_a.id_ready), 32'h1);
    check("nofwd_ready", 32'(bus_b.id_ready), 32'h0);
    tick();
    check("fwd_busa",    bus_a.idex_busa, 32'hAAAA);
    check("fwd_valid",   32'(bus_a.idex_valid), 32'h1);
    check("nofwd_valid", 32'(bus_b.idex_valid), 32'h0);
    check("nofwd_busa",  bus_b.idex_busa, 32'h0);
    bus_a.mem_regwr = 1'b0; bus_a.wb_regwr = 1'b0;
    #1;
    check("nofwd_retry_ready", 32'(bus_b.id_ready), 32'h1);
    tick();
    check("nofwd_retry_busa",  bus_b.idex_busa, 32'h5555);
    check("nofwd_retry_valid", 32'(bus_b.idex_valid), 32'h1);

    // Load-use: lw r4 in EX, add r6,r4,r2 in ID
    bus_a.id_instr = rtype(5'd4, 5'd2, 5'd6, 6'h20);
    bus_a.ex_regwr = 1'b1; bus_a.ex_memrd = 1'b1; bus_a.ex_wrreg = 5'd4;
    #1;
    check("lu_ready", 32'(bus_a.id_ready), 32'h0);
    tick();
    check("lu_bubble", 32'(bus_a.idex_valid), 32'h0);
    bus_a.ex_regwr = 1'b0; bus_a.ex_memrd = 1'b0; bus_a.ex_wrreg = '0;
    bus_a.mem_regwr = 1'b1; bus_a.mem_wrreg = 5'd4; bus_a.mem_data = 32'hBEEF;
    #1;
    check("lu_retry_ready", 32'(bus_a.id_ready), 32'h1);
    tick();
    check("lu_retry_valid", 32'(bus_a.idex_valid), 32'h1);
    check("lu_retry_busa",  bus_a.idex_busa, 32'hBEEF);
    check("lu_retry_wrreg", 32'(bus_a.idex_wrreg), 32'd6);
    bus_a.mem_regwr = 1'b0;

    // Branches: r1=7, r2=7 (r2 through same-cycle write-through)
    bus_a.id_valid = 1'b0;
    bus_a.wb_regwr = 1'b1; bus_a.wb_wrreg = 5'd1; bus_a.wb_data = 32'd7;
    tick();
    bus_a.wb_wrreg = 5'd2; bus_a.wb_data = 32'd7;
    bus_a.id_valid = 1'b1; bus_a.id_pc = 32'h100; bus_a.id_instr = itype(6'h04, 5'd1, 5'd2, 16'hFFFE);
    #1;
    check("beq_flush",  32'(bus_a.ifid_flush), 32'h1);
    check("beq_target", bus_a.branch_target, 32'h0FC);
    tick();
    check("beq_imm",    bus_a.idex_imm, 32'hFFFF_FFFE);
    check("beq_opcode", 32'(bus_a.idex_opcode), 32'h04);
    bus_a.wb_regwr = 1'b0;
    bus_a.id_instr = itype(6'h05, 5'd1, 5'd2, 16'hFFFE);
    #1;
    check("bne_flush",  32'(bus_a.ifid_flush), 32'h0);
    check("bne_target", bus_a.branch_target, 32'h0FC);
    tick();
    bus_a.wb_regwr = 1'b1; bus_a.wb_wrreg = 5'd1; bus_a.wb_data = 32'h8000_0000;
    bus_a.id_instr = itype(6'h01, 5'd1, 5'd0, 16'h0010);
    #1;
    check("bltz_flush",  32'(bus_a.ifid_flush), 32'h1);
    check("bltz_target", bus_a.branch_target, 32'h144);
    tick();
    bus_a.wb_regwr = 1'b0;

    // Branch operand produced by a non-load ALU op in EX still stalls
    bus_a.id_instr = itype(6'h04, 5'd2, 5'd2, 16'h0001);
    bus_a.ex_regwr = 1'b1; bus_a.ex_wrreg = 5'd2;
    #1;
    check("bhaz_ready", 32'(bus_a.id_ready), 32'h0);
    check("bhaz_flush", 32'(bus_a.ifid_flush), 32'h0);
    tick();
    bus_a.ex_regwr = 1'b0; bus_a.ex_wrreg = '0;

    // Backpressure: load an addu, then hold with a taken beq waiting in ID
    bus_a.id_pc = 32'h1FC; bus_a.id_instr = rtype(5'd5, 5'd0, 5'd9, 6'h21);
    tick();
    bus_a.ex_stall = 1'b1;
    bus_a.id_pc = 32'h200; bus_a.id_instr = itype(6'h04, 5'd2, 5'd2, 16'h0001);
    for (int i = 0; i < 3; i++) begin
      bus_a.ex_regwr = (i == 0); bus_a.ex_memrd = (i == 0); bus_a.ex_wrreg = (i == 0) ? 5'd2 : 5'd0;
      #1;
      check("bp_ready", 32'(bus_a.id_ready), 32'h0);
      check("bp_flush", 32'(bus_a.ifid_flush), 32'h0);
      tick();
      check("bp_valid", 32'(bus_a.idex_valid), 32'h1);
      check("bp_pc",    bus_a.idex_pc, 32'h1FC);
      check("bp_busa",  bus_a.idex_busa, 32'h1234);
    end
    bus_a.ex_stall = 1'b0; bus_a.ex_regwr = 1'b0; bus_a.ex_memrd = 1'b0; bus_a.ex_wrreg = '0;
    #1;
    check("rel_flush",  32'(bus_a.ifid_flush), 32'h1);
    check("rel_ready",  32'(bus_a.id_ready), 32'h1);
    check("rel_target", bus_a.branch_target, 32'h208);
    tick();
    check("rel_pc",     bus_a.idex_pc, 32'h200);
    check("rel_opcode", 32'(bus_a.idex_opcode), 32'h04);
    check("rel_busb",   bus_a.idex_busb, 32'd7);

    // r0 ignores writes, including the same-cycle write-through path
    bus_a.id_pc = 32'h300; bus_a.id_instr = rtype(5'd0, 5'd0, 5'd10, 6'h21);
    bus_a.wb_regwr = 1'b1; bus_a.wb_wrreg = 5'd0; bus_a.wb_data = 32'hDEAD;
    tick();
    check("r0_same_busa", bus_a.idex_busa, 32'h0);
    bus_a.wb_regwr = 1'b0;
    tick();
    check("r0_busa", bus_a.idex_busa, 32'h0);
    check("r0_busb", bus_a.idex_busb, 32'h0);

    // jal targets the top register for either register count
    bus_a.id_pc = 32'h400; bus_a.id_instr = {6'h03, 26'h40};
    tick();
    check("jal_wrreg32", 32'(bus_a.idex_wrreg), 32'd31);
    check("jal_wrreg16", 32'(bus_c.idex_wrreg), 32'd15);
    check("jal_opcode",  32'(bus_a.idex_opcode), 32'h03);

    bus_a.id_valid = 1'b0;
    tick();
    check("idle_bubble", 32'(bus_a.idex_valid), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
